apb_master_arbiter: RTL and testbench

- Shares one APB master port between two independent requesters, e.g. CPU-side AHB-APB bridge and a DMA engine.
- Sits between the requesters and the APB decoder/mux that fans out to the 16 slave slots.
- Sequences the APB SETUP/ACCESS phases, waits on PREADY and routes PRDATA back to the granted requester.
- Uses round-robin arbitration with one outstanding transfer at a time.

---
 rtl/apb_arb_pkg.sv | 33 +++
 rtl/apb_master_arbiter_rr_arb2.sv | 37 +++
 rtl/apb_master_arbiter.sv | 171 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package apb_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Read data returned on an aborted transfer (replicated to DATA_W).
    localparam logic ARB_ABORT_RDATA_BIT = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_t;

    // Requester index: 0 or 1.
    typedef logic req_idx_t;

    // Round-robin pick: under contention the requester that did not win last
    // time goes next; otherwise whichever single requester is asking.
    function automatic req_idx_t rr_pick(input logic [1:0] req, input req_idx_t last);
        if (req == 2'b11) begin
            return ~last;
        end else if (req[1]) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arb2.sv
// Two-way round-robin grant with last-grant memory.
// Latency: grant is combinational from req_i; last-grant updates on the next edge.
// Backpressure: grants only while en_i is high; a request not granted simply waits.
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_vld_o,
    output req_idx_t   gnt_idx_o
);

    req_idx_t last_q;
    req_idx_t last_d;

    // Pick a winner and remember it when the grant is actually taken.
    always_comb begin
        gnt_idx_o = rr_pick(req_i, last_q);
        gnt_vld_o = en_i && (req_i != 2'b00);
        last_d    = last_q;
        if (gnt_vld_o) begin
            last_d = gnt_idx_o;
        end
    end

    // Reset to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters, round-robin, one transfer in flight; optional ACCESS timeout under APB_ARB_TIMEOUT_EN.
// Latency: request seen in IDLE -> SETUP next cycle -> done in first ACCESS cycle with PREADY=1 (3 cycles min, +1 per wait state).
// Backpressure: requesters hold valid until their done strobe; PREADY low stretches ACCESS (bounded by TIMEOUT_CYC when enabled).
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,

    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    arb_state_t        state_q, state_d;
    req_idx_t          gnt_q, gnt_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic              arb_vld;
    req_idx_t          arb_idx;
    logic              timeout_hit;
    logic              xfer_end;
    logic              to_abort;
    logic              done_any;
    logic [DATA_W-1:0] rdata_ret;

    // Arbitration only happens in IDLE, so a grant always starts a new transfer.
    rr_arb2 u_rr_arb2 (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .req_i     ({r1_valid, r0_valid}),
        .en_i      (state_q == ARB_IDLE),
        .gnt_vld_o (arb_vld),
        .gnt_idx_o (arb_idx)
    );

`ifdef APB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Count ACCESS cycles without PREADY; cleared whenever not in ACCESS so
    // every transfer enters ACCESS with a zero count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ARB_ACCESS) begin
            cnt_d = 16'd0;
        end else if (!PREADY) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Wait-state counter register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle that would push the count to TIMEOUT_CYC is the last one allowed.
    assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

    // Next-state logic: grant and latch fields in IDLE, fixed SETUP, ACCESS
    // until PREADY (or timeout abort).
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        xfer_end = 1'b0;
        to_abort = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (arb_vld) begin
                    gnt_d    = arb_idx;
                    pwrite_d = arb_idx ? r1_write : r0_write;
                    paddr_d  = arb_idx ? r1_addr  : r0_addr;
                    pwdata_d = arb_idx ? r1_wdata : r0_wdata;
                    state_d  = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (PREADY) begin
                    xfer_end = 1'b1;
                    state_d  = ARB_IDLE;
                end else if (timeout_hit) begin
                    xfer_end = 1'b1;
                    to_abort = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and latched transfer fields; fields hold their value in IDLE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    // APB drive and completion routing back to the granted requester.
    always_comb begin
        PSEL      = (state_q != ARB_IDLE);
        PENABLE   = (state_q == ARB_ACCESS);
        PWRITE    = pwrite_q;
        PADDR     = paddr_q;
        PWDATA    = pwdata_q;
        // A reset landing mid-ACCESS must not produce a completion.
        done_any  = xfer_end && !PRESET;
        rdata_ret = {DATA_W{ARB_ABORT_RDATA_BIT}};
        if (done_any && !pwrite_q && !to_abort) begin
            rdata_ret = PRDATA;
        end
        r0_done   = done_any && (gnt_q == 1'b0);
        r1_done   = done_any && (gnt_q == 1'b1);
        r0_rdata  = r0_done ? rdata_ret : '0;
        r1_rdata  = r1_done ? rdata_ret : '0;
        r0_err    = r0_done && to_abort;
        r1_err    = r1_done && to_abort;
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: cycle-by-cycle vector table plus reset and timeout sequences.
// Latency: each vector row is one PCLK cycle; outputs sampled mid-cycle.
// Backpressure: PREADY driven directly from the vectors.
module tb_apb_master_arbiter;

    logic        PCLK;
    logic        PRESET;
    logic        r0_valid, r0_write, r0_done, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_valid, r1_write, r1_done, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;

    apb_master_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .r0_valid (r0_valid),
        .r0_write (r0_write),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_done  (r0_done),
        .r0_rdata (r0_rdata),
        .r0_err   (r0_err),
        .r1_valid (r1_valid),
        .r1_write (r1_write),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_done  (r1_done),
        .r1_rdata (r1_rdata),
        .r1_err   (r1_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        rst;
        logic        v0, w0;
        logic [31:0] a0, d0;
        logic        v1, w1;
        logic [31:0] a1, d1;
        logic        prdy;
        logic [31:0] prd;
        logic [134:0] exp;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    // {PSEL,PENABLE,PWRITE,PADDR,PWDATA,r0_done,r1_done,r0_rdata,r1_rdata,r0_err,r1_err}
    function automatic logic [134:0] obs();
        return {PSEL, PENABLE, PWRITE, PADDR, PWDATA, r0_done, r1_done, r0_rdata, r1_rdata, r0_err, r1_err};
    endfunction

    task automatic add(input logic rst, v0, w0, input logic [31:0] a0, d0,
                       input logic v1, w1, input logic [31:0] a1, d1,
                       input logic prdy, input logic [31:0] prd,
                       input logic psel, pen, pwr, input logic [31:0] paddr, pwdata,
                       input logic dn0, dn1, input logic [31:0] rd0, rd1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.prdy = prdy; v.prd = prd;
        v.exp = {psel, pen, pwr, paddr, pwdata, dn0, dn1, rd0, rd1, 2'b00};
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [134:0] act, input logic [134:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive(input vec_t v);
        PRESET = v.rst;
        r0_valid = v.v0; r0_write = v.w0; r0_addr = v.a0; r0_wdata = v.d0;
        r1_valid = v.v1; r1_write = v.w1; r1_addr = v.a1; r1_wdata = v.d1;
        PREADY = v.prdy; PRDATA = v.prd;
    endtask

    initial begin
        logic        ppwr, cpwr, g;
        logic [31:0] paddr_p, pwd_p, caddr, cwd;
        int          seen;

        PRESET = 1'b1;
        r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        PREADY = 1'b0; PRDATA = '0;
        step();
        step();

        // Reset state.
        add(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,32'h0,  0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        // Single write by r0, PREADY=1: SETUP in cycle 1, done in cycle 2.
        add(0, 1,1,32'h4,32'hA5A5_0001, 0,0,32'h0,32'h0, 1,32'h1234_5678,  0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        add(0, 1,1,32'h4,32'hA5A5_0001, 0,0,32'h0,32'h0, 1,32'h1234_5678,  1,0,1,32'h4,32'hA5A5_0001, 0,0,32'h0,32'h0);
        add(0, 1,1,32'h4,32'hA5A5_0001, 0,0,32'h0,32'h0, 1,32'h1234_5678,  1,1,1,32'h4,32'hA5A5_0001, 1,0,32'h0,32'h0);
        add(0, 0,1,32'h4,32'hA5A5_0001, 0,0,32'h0,32'h0, 1,32'h1234_5678,  0,0,1,32'h4,32'hA5A5_0001, 0,0,32'h0,32'h0);
        // r1 read of 0x10 with three wait states.
        add(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 0,32'hDEAD_BEEF,  0,0,1,32'h4,32'hA5A5_0001, 0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 0,32'hDEAD_BEEF,  1,0,0,32'h10,32'h0, 0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 0,32'hDEAD_BEEF,  1,1,0,32'h10,32'h0, 0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 0,32'hDEAD_BEEF,  1,1,0,32'h10,32'h0, 0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 0,32'hDEAD_BEEF,  1,1,0,32'h10,32'h0, 0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 1,32'hDEAD_BEEF,  1,1,0,32'h10,32'h0, 0,1,32'h0,32'hDEAD_BEEF);
        add(0, 0,0,32'h0,32'h0, 0,0,32'h10,32'h0, 1,32'hDEAD_BEEF,  0,0,0,32'h10,32'h0, 0,0,32'h0,32'h0);

        // Contention: both valid for 8 transfers; r0 writes, r1 reads; strict alternation starting with r0.
        ppwr = 1'b0; paddr_p = 32'h10; pwd_p = 32'h0;
        for (int k = 0; k < 8; k++) begin
            g     = (k % 2) == 1;
            cpwr  = g ? 1'b0 : 1'b1;
            caddr = g ? 32'h200 : 32'h100;
            cwd   = g ? 32'h2222_2222 : 32'h1111_1111;
            add(0, 1,1,32'h100,32'h1111_1111, 1,0,32'h200,32'h2222_2222, 1,32'h0BAD_F00D,  0,0,ppwr,paddr_p,pwd_p, 0,0,32'h0,32'h0);
            add(0, 1,1,32'h100,32'h1111_1111, 1,0,32'h200,32'h2222_2222, 1,32'h0BAD_F00D,  1,0,cpwr,caddr,cwd, 0,0,32'h0,32'h0);
            add(0, 1,1,32'h100,32'h1111_1111, 1,0,32'h200,32'h2222_2222, 1,32'h0BAD_F00D,  1,1,cpwr,caddr,cwd, !g,g,32'h0,(g ? 32'h0BAD_F00D : 32'h0));
            ppwr = cpwr; paddr_p = caddr; pwd_p = cwd;
        end
        add(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,32'h0BAD_F00D,  0,0,0,32'h200,32'h2222_2222, 0,0,32'h0,32'h0);

        // Field change after grant: r0 moves its address 0x8 -> 0xC during SETUP.
        add(0, 1,0,32'h8,32'h0, 0,0,32'h0,32'h0, 1,32'h1234_5678,  0,0,0,32'h200,32'h2222_2222, 0,0,32'h0,32'h0);
        add(0, 1,0,32'hC,32'h0, 0,0,32'h0,32'h0, 1,32'h1234_5678,  1,0,0,32'h8,32'h0, 0,0,32'h0,32'h0);
        add(0, 1,0,32'hC,32'h0, 0,0,32'h0,32'h0, 1,32'h1234_5678,  1,1,0,32'h8,32'h0, 1,0,32'h1234_5678,32'h0);
        add(0, 0,0,32'hC,32'h0, 0,0,32'h0,32'h0, 1,32'h1234_5678,  0,0,0,32'h8,32'h0, 0,0,32'h0,32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #4;
            check($sformatf("vec%0d", i), obs(), vq[i].exp);
            step();
        end

        // Reset asserted in ACCESS with PREADY=0.
        r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 32'h20; r0_wdata = 32'h33;
        PREADY = 1'b0; PRDATA = 32'h0;
        #4; check("rst_idle", 135'(PSEL), 135'(0));
        step();
        #4; check("rst_setup", 135'({PSEL, PENABLE}), 135'(2'b10));
        step();
        PRESET = 1'b1;
        #4; check("rst_nodone", 135'({r0_done, r1_done}), 135'(0));
        step();
        PRESET = 1'b0; r0_valid = 1'b0;
        #4; check("rst_clear", 135'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 135'(0));
        step();
        r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 32'h40; r1_wdata = 32'h44; PREADY = 1'b1;
        #4; check("post_rst_idle", 135'(PSEL), 135'(0));
        step();
        #4; check("post_rst_setup", 135'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), {68'h0, 3'b101, 32'h40, 32'h44});
        step();
        #4; check("post_rst_done", 135'({PENABLE, r1_done, r0_done}), 135'(3'b110));
        step();
        r1_valid = 1'b0;

        // Stuck PREADY: abort with the timeout, or wait indefinitely without it.
        r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 32'h50; r0_wdata = 32'h0;
        PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
        #4;
        step();
        #4;
        step();
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            #4; check($sformatf("to_wait%0d", i), 135'({r0_done, r0_err}), 135'(0));
            step();
        end
        #4; check("to_abort", 135'({r0_done, r0_err, r0_rdata}), {100'h0, 2'b11, 32'h0});
        step();
        r0_valid = 1'b0;
        #4; check("to_idle", 135'({PSEL, PENABLE}), 135'(0));
        step();
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            #4;
            if (r0_done || r1_done) seen++;
            step();
        end
        check("pending_nodone", 135'(seen), 135'(0));
        check("pending_access", 135'({PSEL, PENABLE}), 135'(2'b11));
        r0_valid = 1'b0;
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
